vid_timing_gen: RTL
===================

Name: vid_timing_gen

Overview:
- Parametrised video timing generator for the HDMI output path; replaces the fixed-resolution timing IP core.
- Produces hsync, vsync and DE with configurable polarity, plus a FIFO read request that leads DE by a configurable number of cycles to absorb frame-buffer FIFO read latency.
- Delays the sync and DE outputs by a configurable amount to align with the downstream raw2rgb/gamma pipeline.
- Supports run/stop control that takes effect only at frame boundaries, and outputs active-pixel coordinates.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- RD_LEAD, 1, cycles by which o_fifo_rd_en leads undelayed DE; legal range 0..H_SYNC+H_BP
- PIPE_DLY, 2, extra register stages on sync/DE/coordinate outputs; legal range 0..15
- CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- sclk  in  1  pixel clock
- s_rst  in  1  synchronous reset, active-high
- en  in  1  run request
- o_running  out  1  generator is in RUN or STOP_PEND
- o_fifo_rd_en  out  1  pixel read request to frame FIFO
- o_hsync  out  1  horizontal sync, polarity HS_POL
- o_vsync  out  1  vertical sync, polarity VS_POL
- o_de  out  1  active video
- o_x  out  CNT_W  active pixel column, aligned with o_de
- o_y  out  CNT_W  active line, aligned with o_de
- o_frame_start  out  1  one-cycle pulse at h=0, v=0 (undelayed)

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL defined the same way from the vertical parameters.
- Horizontal order: sync [0,H_SYNC), back porch, active [HA0=H_SYNC+H_BP, HA1=HA0+H_ACTIVE), front porch. Vertical order is the same per line, giving active lines [VA0, VA1).
- hcnt wraps at H_TOTAL-1 to 0. vcnt increments on the hcnt wrap and wraps at V_TOTAL-1.
- FSM:
  - IDLE → RUN when en=1. The first counted cycle has h=0, v=0, and o_frame_start=1 on that cycle.
  - RUN → STOP_PEND when en=0.
  - STOP_PEND → RUN when en=1; the frame continues uninterrupted.
  - STOP_PEND → IDLE on the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - In IDLE, counters are held at 0.
- Stage 0 (registered from counters, valid only in RUN/STOP_PEND):
  - hs0 = h<H_SYNC
  - vs0 = v<V_SYNC
  - de0 = h in [HA0,HA1) and v in [VA0,VA1)
  - x0 = h-HA0 and y0 = v-VA0, each forced to 0 when de0=0
- o_fifo_rd_en = registered (h in [HA0-RD_LEAD, HA1-RD_LEAD) and v in [VA0,VA1)). It asserts exactly RD_LEAD cycles before de0 and is never delayed by PIPE_DLY. Because of the RD_LEAD bound, no wrap across lines occurs.
- Output stage:
  - hs0, vs0, de0, x0 and y0 pass through a PIPE_DLY-deep shift register; PIPE_DLY=0 is direct.
  - Polarity is applied at the output: o_hsync = hs ^ ~HS_POL, and o_vsync is formed the same way with VS_POL.
  - Total o_de lag behind o_fifo_rd_en is RD_LEAD+PIPE_DLY cycles.
- Outside RUN/STOP_PEND, stage 0 is inactive: syncs at their inactive level, de=0, rd_en=0. The delay line keeps shifting, so it drains naturally.
- Reset values (any time, including mid-frame): state IDLE, counters 0, all delay stages inactive. Outputs: o_running=0, o_fifo_rd_en=0, o_de=0, o_x=o_y=0, o_frame_start=0, o_hsync=~HS_POL, o_vsync=~VS_POL.
- Reset wins over en in the same cycle.
- Per frame, o_fifo_rd_en and o_de each assert exactly H_ACTIVE×V_ACTIVE cycles.

Decomposition:
- Package vid_timing_pkg: FSM state enum (IDLE, RUN, STOP_PEND); derived localparams H_TOTAL, V_TOTAL, HA0, HA1, VA0, VA1; preset parameter sets for 720p60 and 1080p30.
- One sub-module, vid_delay_line: parametrised width × depth shift register with synchronous reset to a per-bit reset value. It is used once, on the concatenated {hs, vs, de, x, y} bus.

Test Plan:
- Small config (H: ACTIVE 8, FP 2, SYNC 2, BP 3; V: ACTIVE 4, FP 1, SYNC 1, BP 1; RD_LEAD=1, PIPE_DLY=2), en held 1 → H_TOTAL=15 and V_TOTAL=7. o_frame_start fires every 105 cycles. 32 o_de cycles per frame. hsync active 2 of every 15 cycles.
- Same config → first o_fifo_rd_en rise precedes first o_de rise by exactly 3 cycles. o_x runs 0..7 and o_y 0..3 while o_de=1.
- Deassert en at mid-frame cycle 40 → frame completes (32 DE cycles total), o_running falls after cycle 104, then all outputs are inactive. Reassert en 10 cycles later → o_frame_start fires on the next cycle.
- Deassert en at cycle 40, reassert at cycle 50 → no gap: next o_frame_start at cycle 105.
- Assert s_rst at cycle 60 while o_de=1 → next cycle o_de=0, o_fifo_rd_en=0, o_hsync and o_vsync at inactive level. Restart produces a frame identical to the first.
- HS_POL=0, VS_POL=0, PIPE_DLY=0, RD_LEAD=0 → syncs idle high and pulse low. o_fifo_rd_en coincides with o_de cycle-for-cycle.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: shared types, helpers and resolution presets
// for the HDMI video timing generator.
package vid_timing_pkg;

   // Generator run state; STOP_PEND finishes the current frame.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STOP_PEND = 2'd2
   } state_e;

   // Full period of one axis (line or frame) in counts.
   function automatic int axis_total(
      input int act,
      input int fp,
      input int sync,
      input int bp
   );
      return act + fp + sync + bp;
   endfunction

   // First active count of an axis: sync then back porch precede it.
   function automatic int axis_act0(
      input int sync,
      input int bp
   );
      return sync + bp;
   endfunction

   // 1280x720 @ 60 Hz, 74.25 MHz pixel clock.
   localparam int P720_H_ACTIVE = 1280;
   localparam int P720_H_FP     = 110;
   localparam int P720_H_SYNC   = 40;
   localparam int P720_H_BP     = 220;
   localparam int P720_V_ACTIVE = 720;
   localparam int P720_V_FP     = 5;
   localparam int P720_V_SYNC   = 5;
   localparam int P720_V_BP     = 20;

   localparam int P720_H_TOTAL =
      axis_total(P720_H_ACTIVE, P720_H_FP, P720_H_SYNC, P720_H_BP);
   localparam int P720_V_TOTAL =
      axis_total(P720_V_ACTIVE, P720_V_FP, P720_V_SYNC, P720_V_BP);
   localparam int P720_HA0 = axis_act0(P720_H_SYNC, P720_H_BP);
   localparam int P720_HA1 = P720_HA0 + P720_H_ACTIVE;
   localparam int P720_VA0 = axis_act0(P720_V_SYNC, P720_V_BP);
   localparam int P720_VA1 = P720_VA0 + P720_V_ACTIVE;

   // 1920x1080 @ 30 Hz, 74.25 MHz pixel clock.
   localparam int P1080_H_ACTIVE = 1920;
   localparam int P1080_H_FP     = 88;
   localparam int P1080_H_SYNC   = 44;
   localparam int P1080_H_BP     = 148;
   localparam int P1080_V_ACTIVE = 1080;
   localparam int P1080_V_FP     = 4;
   localparam int P1080_V_SYNC   = 5;
   localparam int P1080_V_BP     = 36;

   localparam int P1080_H_TOTAL =
      axis_total(P1080_H_ACTIVE, P1080_H_FP, P1080_H_SYNC, P1080_H_BP);
   localparam int P1080_V_TOTAL =
      axis_total(P1080_V_ACTIVE, P1080_V_FP, P1080_V_SYNC, P1080_V_BP);
   localparam int P1080_HA0 = axis_act0(P1080_H_SYNC, P1080_H_BP);
   localparam int P1080_HA1 = P1080_HA0 + P1080_H_ACTIVE;
   localparam int P1080_VA0 = axis_act0(P1080_V_SYNC, P1080_V_BP);
   localparam int P1080_VA1 = P1080_VA0 + P1080_V_ACTIVE;

endpackage

// File: rtl/vid_delay_line.sv
// vid_delay_line: WIDTH x DEPTH shift register, each stage
// resetting to RST_VAL; DEPTH of 0 is a plain wire.
module vid_delay_line
   import vid_timing_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   if (DEPTH == 0) begin : g_wire

      logic unused_ctl;
      assign unused_ctl = clk ^ rst;
      assign o_data     = i_data;

   end else begin : g_pipe

      logic [WIDTH-1:0] stg_q [DEPTH];
      logic [WIDTH-1:0] stg_d [DEPTH];

      // Each stage takes the previous one; stage 0 takes the input.
      always_comb begin
         stg_d[0] = i_data;
         for (int i = 1; i < DEPTH; i++) begin
            stg_d[i] = stg_q[i-1];
         end
      end

      // Stage registers; reset forces every stage inactive.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stg_q[i] <= RST_VAL;
            end
         end else begin
            stg_q <= stg_d;
         end
      end

      assign o_data = stg_q[DEPTH-1];

   end

endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: parametrised video timing generator with
// frame-boundary run/stop, FIFO read lead and output delay.
module vid_timing_gen
   import vid_timing_pkg::*;
#(
   parameter int H_ACTIVE = P720_H_ACTIVE,
   parameter int H_FP     = P720_H_FP,
   parameter int H_SYNC   = P720_H_SYNC,
   parameter int H_BP     = P720_H_BP,
   parameter int V_ACTIVE = P720_V_ACTIVE,
   parameter int V_FP     = P720_V_FP,
   parameter int V_SYNC   = P720_V_SYNC,
   parameter int V_BP     = P720_V_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int RD_LEAD  = 1,
   parameter int PIPE_DLY = 2,
   parameter int CNT_W    = 12
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic             en,
   output logic             o_running,
   output logic             o_fifo_rd_en,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_frame_start
);

   localparam int H_TOTAL =
      axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL =
      axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HA0 = axis_act0(H_SYNC, H_BP);
   localparam int HA1 = HA0 + H_ACTIVE;
   localparam int VA0 = axis_act0(V_SYNC, V_BP);
   localparam int VA1 = VA0 + V_ACTIVE;

   // Read window is the active window shifted early by RD_LEAD;
   // RD_LEAD never exceeds HA0, so it stays inside one line.
   localparam int HR0 = HA0 - RD_LEAD;
   localparam int HR1 = HA1 - RD_LEAD;

   localparam int BUS_W = 3 + 2 * CNT_W;

   localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_HS_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] C_VS_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] C_HA0    = CNT_W'(HA0);
   localparam logic [CNT_W-1:0] C_HA1    = CNT_W'(HA1);
   localparam logic [CNT_W-1:0] C_VA0    = CNT_W'(VA0);
   localparam logic [CNT_W-1:0] C_VA1    = CNT_W'(VA1);
   localparam logic [CNT_W-1:0] C_HR0    = CNT_W'(HR0);
   localparam logic [CNT_W-1:0] C_HR1    = CNT_W'(HR1);

   state_e state_q;
   state_e state_d;

   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] h_d;
   logic [CNT_W-1:0] v_q;
   logic [CNT_W-1:0] v_d;

   logic             active;
   logic             frame_start;
   logic             h_last;
   logic             v_last;
   logic             frame_last;

   logic             hs0_q;
   logic             hs0_d;
   logic             vs0_q;
   logic             vs0_d;
   logic             de0_q;
   logic             de0_d;
   logic             rd_q;
   logic             rd_d;
   logic [CNT_W-1:0] x0_q;
   logic [CNT_W-1:0] x0_d;
   logic [CNT_W-1:0] y0_q;
   logic [CNT_W-1:0] y0_d;

   logic             h_act;
   logic             h_rd;
   logic             v_act;

   logic [BUS_W-1:0] s0_bus;
   logic [BUS_W-1:0] dl_bus;
   logic             hs_dl;
   logic             vs_dl;
   logic             de_dl;

   assign h_last     = (h_q == C_H_LAST);
   assign v_last     = (v_q == C_V_LAST);
   assign frame_last = h_last && v_last;

   // FSM state register.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; stopping only completes on the last frame cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en) state_d = ST_STOP_PEND;
         end
         ST_STOP_PEND: begin
            if (en) begin
               state_d = ST_RUN;
            end else if (frame_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: running flag and undelayed frame-start pulse.
   always_comb begin
      active      = (state_q == ST_RUN) ||
                    (state_q == ST_STOP_PEND);
      frame_start = active && (h_q == '0) && (v_q == '0);
   end

   // Raster counters advance only while running, else hold at 0.
   always_comb begin
      h_d = '0;
      v_d = '0;
      if (active) begin
         h_d = h_last ? '0 : h_q + CNT_W'(1);
         v_d = v_q;
         if (h_last) begin
            v_d = v_last ? '0 : v_q + CNT_W'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Stage 0 decode of the counters, gated off when not running.
   always_comb begin
      h_act = (h_q >= C_HA0) && (h_q < C_HA1);
      h_rd  = (h_q >= C_HR0) && (h_q < C_HR1);
      v_act = (v_q >= C_VA0) && (v_q < C_VA1);
      hs0_d = active && (h_q < C_HS_END);
      vs0_d = active && (v_q < C_VS_END);
      de0_d = active && h_act && v_act;
      rd_d  = active && h_rd && v_act;
      x0_d  = de0_d ? h_q - C_HA0 : '0;
      y0_d  = de0_d ? v_q - C_VA0 : '0;
   end

   // Stage 0 registers, including the undelayed read request.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         hs0_q <= 1'b0;
         vs0_q <= 1'b0;
         de0_q <= 1'b0;
         rd_q  <= 1'b0;
         x0_q  <= '0;
         y0_q  <= '0;
      end else begin
         hs0_q <= hs0_d;
         vs0_q <= vs0_d;
         de0_q <= de0_d;
         rd_q  <= rd_d;
         x0_q  <= x0_d;
         y0_q  <= y0_d;
      end
   end

   assign s0_bus = {hs0_q, vs0_q, de0_q, x0_q, y0_q};

   vid_delay_line #(
      .WIDTH   (BUS_W),
      .DEPTH   (PIPE_DLY),
      .RST_VAL ('0)
   ) u_dly (
      .clk    (sclk),
      .rst    (s_rst),
      .i_data (s0_bus),
      .o_data (dl_bus)
   );

   assign {hs_dl, vs_dl, de_dl, o_x, o_y} = dl_bus;

   // Delay stages carry active-high syncs; polarity is applied last.
   assign o_hsync       = hs_dl ^ ~HS_POL;
   assign o_vsync       = vs_dl ^ ~VS_POL;
   assign o_de          = de_dl;
   assign o_fifo_rd_en  = rd_q;
   assign o_running     = active;
   assign o_frame_start = frame_start;

endmodule
